// File: rtl/pulse_arb_pkg.sv
// Shared types and default sizing for pulse_event_arbiter.
package pulse_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  localparam int unsigned DEF_NUM_SRC = 4;
  localparam int unsigned DEF_CNT_W   = 4;

endpackage

// File: rtl/pulse_event_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above i_ptr, wrapping.
module rr_pick
  import pulse_arb_pkg::*;
#(
  parameter int unsigned N   = DEF_NUM_SRC,
  parameter int unsigned IDW = $clog2(DEF_NUM_SRC)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic           o_found,
  output logic [IDW-1:0] o_idx
);

  always_comb begin
    int unsigned s;
    logic [IDW-1:0] w_j;
    o_found = 1'b0;
    o_idx   = '0;
    s       = 0;
    w_j     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      s = 32'(i_ptr) + k;
      if (s >= N) s = s - N;
      w_j = IDW'(s);
      if (!o_found && i_req[w_j]) begin
        o_found = 1'b1;
        o_idx   = w_j;
      end
    end
  end

endmodule

// File: rtl/pulse_event_arbiter.sv
// Per-source pending-event counters serialized onto one valid/ready channel, round-robin.
// Optional overflow flags enabled by defining PULSE_EVENT_ARB_OVF_EN.
module pulse_event_arbiter
  import pulse_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC = DEF_NUM_SRC,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned ID_W    = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] pulse_in,
  output logic               ev_valid,
  output logic [ID_W-1:0]    ev_id,
  input  logic               ev_ready,
  output logic               pend_any,
  output logic [NUM_SRC-1:0] ovf,
  input  logic [NUM_SRC-1:0] ovf_clr
);

  arb_state_t         r_state;
  logic               r_ev_valid;
  logic [ID_W-1:0]    r_ev_id;
  logic [ID_W-1:0]    r_rr_ptr;
  logic               w_xfer;
  logic [NUM_SRC-1:0] w_dec;
  logic [NUM_SRC-1:0] w_req;
  logic [NUM_SRC-1:0] w_sat_hit;
  logic               w_found;
  logic [ID_W-1:0]    w_pick;

  assign w_xfer = r_ev_valid && ev_ready;

  for (genvar g = 0; g < NUM_SRC; g++) begin : gen_src
    logic [CNT_W-1:0] r_cnt;

    assign w_dec[g]     = w_xfer && (r_ev_id == ID_W'(g));
    assign w_req[g]     = (r_cnt != '0);
    // A pulse with no same-cycle drain of this source while already at max is lost.
    assign w_sat_hit[g] = pulse_in[g] && !w_dec[g] && (r_cnt == '1);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (pulse_in[g] && !w_dec[g]) begin
        if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
      end else if (!pulse_in[g] && w_dec[g]) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  rr_pick #(
    .N   (NUM_SRC),
    .IDW (ID_W)
  ) u_rr_pick (
    .i_req   (w_req),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ev_valid <= 1'b0;
      r_ev_id    <= '0;
      r_rr_ptr   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state    <= OFFER;
            r_ev_valid <= 1'b1;
            r_ev_id    <= w_pick;
          end
        end
        OFFER: begin
          if (ev_ready) begin
            r_state    <= IDLE;
            r_ev_valid <= 1'b0;
            r_rr_ptr   <= (r_ev_id == ID_W'(NUM_SRC - 1)) ? '0 : r_ev_id + ID_W'(1);
          end
        end
        default: begin
          r_state    <= IDLE;
          r_ev_valid <= 1'b0;
        end
      endcase
    end
  end

  assign ev_valid = r_ev_valid;
  assign ev_id    = r_ev_id;
  assign pend_any = |w_req;

`ifdef PULSE_EVENT_ARB_OVF_EN
  logic [NUM_SRC-1:0] r_ovf;

  // Set is OR-ed in after the clear so a same-cycle set wins.
  always_ff @(posedge clk) begin
    if (rst) r_ovf <= '0;
    else     r_ovf <= (r_ovf & ~ovf_clr) | w_sat_hit;
  end

  assign ovf = r_ovf;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = ^{ovf_clr, w_sat_hit};
  assign ovf          = '0;
`endif

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Scoreboard bench for pulse_event_arbiter: stimulus pushes expected grant ids, monitor pops on transfers.
module tb_pulse_event_arbiter;

  localparam int unsigned NSRC = 4;
  localparam int unsigned CW   = 4;
  localparam int unsigned IW   = 2;

`ifdef PULSE_EVENT_ARB_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic [NSRC-1:0] pulse_in;
  logic            ev_valid;
  logic [IW-1:0]   ev_id;
  logic            ev_ready;
  logic            pend_any;
  logic [NSRC-1:0] ovf;
  logic [NSRC-1:0] ovf_clr;

  int n_checks = 0;
  int n_errors = 0;
  int unsigned sb[$];

  pulse_event_arbiter #(
    .NUM_SRC (NSRC),
    .CNT_W   (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pulse_in (pulse_in),
    .ev_valid (ev_valid),
    .ev_id    (ev_id),
    .ev_ready (ev_ready),
    .pend_any (pend_any),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 200; k++) begin
      cyc();
      if (!ev_valid && !pend_any) break;
    end
    chk({name, "_timeout"}, 32'(k < 200), 32'd1);
    chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every accepted event must match the next expected id.
  always @(negedge clk) begin
    if (!rst && ev_valid && ev_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_grant: got id %0d expected none", ev_id);
      end else begin
        chk("grant_id", 32'(ev_id), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_v [7];
    logic [IW-1:0] exp_i [7];
    rst      = 1'b1;
    pulse_in = '0;
    ev_ready = 1'b0;
    ovf_clr  = '0;
    cyc();
    cyc();
    rst = 1'b0;

    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_id", 32'(ev_id), 32'd0);
    chk("rst_pend", 32'(pend_any), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    // Single pulse on source 2: offered two cycles later.
    ev_ready = 1'b1;
    pulse_in = 4'b0100;
    sb.push_back(2);
    cyc();
    pulse_in = '0;
    chk("t1_valid_n1", 32'(ev_valid), 32'd0);
    chk("t1_pend_n1", 32'(pend_any), 32'd1);
    cyc();
    chk("t1_valid_n2", 32'(ev_valid), 32'd1);
    chk("t1_id_n2", 32'(ev_id), 32'd2);
    cyc();
    chk("t1_valid_n3", 32'(ev_valid), 32'd0);
    chk("t1_pend_n3", 32'(pend_any), 32'd0);

    // Simultaneous pulses 0,1,3 from a fresh pointer: 0,1,3 with IDLE gaps.
    do_reset();
    ev_ready = 1'b1;
    pulse_in = 4'b1011;
    sb.push_back(0);
    sb.push_back(1);
    sb.push_back(3);
    cyc();
    pulse_in = '0;
    exp_v = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_i = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd3};
    for (int c = 0; c < 7; c++) begin
      chk($sformatf("t2_valid_c%0d", c), 32'(ev_valid), 32'(exp_v[c]));
      if (exp_v[c]) chk($sformatf("t2_id_c%0d", c), 32'(ev_id), 32'(exp_i[c]));
      cyc();
    end
    // Pointer wrapped to 0: with 0 and 3 pending, 0 goes first.
    pulse_in = 4'b1001;
    sb.push_back(0);
    sb.push_back(3);
    cyc();
    pulse_in = '0;
    wait_idle("t2");

    // Back-pressure: offer of source 1 held stable, more pulses accumulate.
    ev_ready = 1'b0;
    pulse_in = 4'b0010;
    sb.push_back(1);
    cyc();
    pulse_in = '0;
    cyc();
    for (int c = 0; c < 10; c++) begin
      pulse_in = (c < 3) ? 4'b0010 : 4'b0000;
      if (c < 3) sb.push_back(1);
      chk($sformatf("t3_valid_c%0d", c), 32'(ev_valid), 32'd1);
      chk($sformatf("t3_id_c%0d", c), 32'(ev_id), 32'd1);
      cyc();
    end
    pulse_in = '0;
    ev_ready = 1'b1;
    wait_idle("t3");

    // Saturation of source 0 at 15 and overflow flag behaviour.
    ev_ready = 1'b0;
    for (int c = 0; c < 15; c++) begin
      pulse_in = 4'b0001;
      sb.push_back(0);
      cyc();
    end
    chk("t4_ovf_at_max", 32'(ovf), 32'd0);
    cyc();
    pulse_in = '0;
    chk("t4_ovf_set", 32'(ovf[0]), 32'(OVF_EXP));
    chk("t4_ovf_others", 32'(ovf[3:1]), 32'd0);
    ovf_clr = 4'b0001;
    cyc();
    ovf_clr = '0;
    chk("t4_ovf_clr", 32'(ovf), 32'd0);
    ev_ready = 1'b1;
    wait_idle("t4");

    // Pulse coinciding with the transfer of the same source keeps count at 1.
    ev_ready = 1'b0;
    pulse_in = 4'b0010;
    sb.push_back(1);
    cyc();
    pulse_in = '0;
    cyc();
    chk("t5_valid", 32'(ev_valid), 32'd1);
    ev_ready = 1'b1;
    pulse_in = 4'b0010;
    sb.push_back(1);
    cyc();
    pulse_in = '0;
    chk("t5_idle_valid", 32'(ev_valid), 32'd0);
    chk("t5_idle_pend", 32'(pend_any), 32'd1);
    cyc();
    chk("t5_reoffer_valid", 32'(ev_valid), 32'd1);
    chk("t5_reoffer_id", 32'(ev_id), 32'd1);
    wait_idle("t5");

    // Reset mid-offer discards pending events.
    ev_ready = 1'b0;
    pulse_in = 4'b0110;
    cyc();
    pulse_in = '0;
    cyc();
    chk("t6_valid_before", 32'(ev_valid), 32'd1);
    do_reset();
    chk("t6_valid_after", 32'(ev_valid), 32'd0);
    chk("t6_pend_after", 32'(pend_any), 32'd0);
    ev_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cyc();
      chk($sformatf("t6_quiet_c%0d", c), 32'(ev_valid), 32'd0);
    end
    pulse_in = 4'b1000;
    sb.push_back(3);
    cyc();
    pulse_in = '0;
    wait_idle("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pulse_event_arbiter.md
# pulse_event_arbiter

Collects single-cycle event pulses from `NUM_SRC` independent sources (typically the `sync_pulse` outputs of bit synchronizers, already in this block's clock domain). It counts pending events per source so that no pulse is lost, and serializes them onto one valid/ready event channel using round-robin arbitration. It sits between the CDC synchronizer bank and a single consumer, for example an interrupt controller or a status FIFO writer.

## Interface
- `NUM_SRC`, default 4: number of pulse sources; minimum 2.
- `CNT_W`, default 4: pending-counter width per source; saturates at 2^CNT_W−1.
- `ID_W`, default `$clog2(NUM_SRC)`: derived width of `ev_id`.
- `clk` input, 1 bit: single clock.
- `rst` input, 1 bit: synchronous, active-high reset.
- `pulse_in` input, `NUM_SRC` bits: event pulses. Every cycle a bit is high counts as one event.
- `ev_valid` output, 1 bit: an event is offered.
- `ev_id` output, `ID_W` bits: source index of the offered event.
- `ev_ready` input, 1 bit: consumer accepts the offered event.
- `pend_any` output, 1 bit: at least one pending counter is nonzero.
- `ovf` output, `NUM_SRC` bits: sticky per-source overflow flags.
- `ovf_clr` input, `NUM_SRC` bits: per-bit clear for `ovf`.

## Operation
- State machine states:
  - IDLE: no event is offered.
  - OFFER: `ev_valid`=1.
- Pending counters `cnt[i]`, updated at each edge:
  - Increment if `pulse_in[i]` is high.
  - Decrement if a transfer of source `i` occurs (`ev_valid && ev_ready && ev_id==i`).
  - If both happen, the counter is unchanged.
  - The counter never underflows, because only a nonzero source is ever offered.
- Saturation: if `cnt[i]`=max and a pulse arrives without a same-cycle transfer of `i`, the count stays at max and `ovf[i]` is set.
- `ovf_clr[i]` clears `ovf[i]`. If a set and a clear occur in the same cycle, the set wins.
- IDLE→OFFER: when any counter is nonzero, pick the first nonzero index scanning upward from `rr_ptr`, with wrap-around. Register the result into `ev_id` and set `ev_valid`.
- OFFER: `ev_id` and `ev_valid` are held stable until a transfer occurs.
- On transfer:
  - `rr_ptr` ← (`ev_id`+1) mod `NUM_SRC`.
  - The FSM returns to IDLE for exactly one cycle, then re-arbitrates.
- `pend_any` is the OR of all counters being nonzero, taken from registered counter values.
- Reset: counters=0, `ovf`=0, `rr_ptr`=0, state=IDLE, `ev_valid`=0, `ev_id`=0, `pend_any`=0.
- A reset asserted mid-OFFER drops `ev_valid` on the next edge. Pending events are discarded.

## Timing
- Latency: a pulse high in cycle N increments the counter at the end of N. Arbitration registers at the end of N+1, so `ev_valid`=1 in cycle N+2.
- Throughput: at most one event per 2 cycles, because of the OFFER→IDLE→OFFER sequence.
- `ev_valid` does not depend combinationally on `ev_ready`. All outputs are registered.
- `pend_any` lags the counters by 0 cycles because it is derived from the registered counters. It is combinational on flops only.

## Configuration
- Macro `PULSE_EVENT_ARB_OVF_EN`.
- Defined:
  - Saturation detection and the `ovf` register are implemented as described.
- Undefined:
  - `ovf` is tied to 0 and `ovf_clr` is ignored.
  - Counters still saturate silently, with no overflow logic.

## Structure
- Package `pulse_arb_pkg` holds:
  - The state typedef `arb_state_t` (IDLE, OFFER).
  - Default localparams for `NUM_SRC` and `CNT_W`.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: request vector and `rr_ptr`.
  - Outputs: `found` and index.
  - It is instantiated once.

## Test plan
- Reset then a single pulse on source 2 (`NUM_SRC`=4), with `ev_ready`=1:
  - `ev_valid` rises 2 cycles after the pulse with `ev_id`=2.
  - `cnt[2]` returns to 0 after the transfer.
  - `pend_any` then falls.
- Simultaneous pulses on sources 0, 1 and 3 with `ev_ready`=1:
  - Grants are issued in the order 0, 1, 3.
  - Each is separated by one IDLE cycle.
  - `rr_ptr` ends at 0.
- `ev_ready`=0 for 10 cycles while an event from source 1 is offered:
  - `ev_valid` and `ev_id`=1 stay stable throughout.
  - Further pulses on source 1 raise `cnt[1]` to 4.
- 16 consecutive pulses on source 0 with `CNT_W`=4 and `ev_ready`=0:
  - `cnt[0]`=15.
  - `ovf[0]`=1 with the macro defined, and 0 with it undefined.
  - `ovf_clr[0]` then clears the flag.
- Pulse on source 1 in the same cycle as the transfer of source 1, with `cnt`=1:
  - `cnt[1]` stays at 1.
  - The next offer is again `ev_id`=1.
- `rst` asserted while `ev_valid`=1 with pending counts:
  - The next cycle shows `ev_valid`=0 and `pend_any`=0.
  - No grants occur until new pulses arrive.
